// File: rtl/execute_stage_pkg.sv
// Execute stage shared definitions: ALU opcodes,
// register-index width and EX/MEM bubble values.
package execute_stage_pkg;

  localparam int REG_W = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // A bubble writes x0 and never signals a taken branch
  localparam logic [REG_W-1:0] BUBBLE_REG  = '0;
  localparam logic             BUBBLE_ZERO = 1'b0;

endpackage

// File: rtl/execute_stage_if.sv
// EX inputs and EX/MEM outputs of the execute stage.
// The slave side is the stage itself.
interface execute_stage_if
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0] pcE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] rd2E;
  logic [WIDTH-1:0] SignImmE;
  logic             ALUSrcE;
  logic [2:0]       AluControlE;
  logic [WIDTH-1:0] WriteDataE;
  logic [REG_W-1:0] WriteRegE;

  logic [WIDTH-1:0] AluResultE;
  logic [WIDTH-1:0] ALUOutM;
  logic             zeroM;
  logic [WIDTH-1:0] BranchTargetM;
  logic [WIDTH-1:0] WriteDataM;
  logic [WIDTH-1:0] pcM;
  logic [REG_W-1:0] WriteRegM;

  modport master (
    output pcE, SrcAE, rd2E, SignImmE,
    output ALUSrcE, AluControlE,
    output WriteDataE, WriteRegE,
    input  AluResultE, ALUOutM, zeroM,
    input  BranchTargetM, WriteDataM,
    input  pcM, WriteRegM
  );

  modport slave (
    input  pcE, SrcAE, rd2E, SignImmE,
    input  ALUSrcE, AluControlE,
    input  WriteDataE, WriteRegE,
    output AluResultE, ALUOutM, zeroM,
    output BranchTargetM, WriteDataM,
    output pcM, WriteRegM
  );

endinterface

// File: rtl/execute_stage_alu.sv
// Purely combinational ALU for the execute stage.
// Shifts use the low five bits of b.
module ex_alu
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic [4:0] shamt;
  logic       lt;

  assign shamt = b[4:0];
  assign lt    = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    unique case (control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: B-operand select, ALU, branch
// target adder and the EX/MEM pipeline register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            flush,
  execute_stage_if.slave  ex
);

  logic [WIDTH-1:0] srcB;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] target;
  logic             zero;

  assign srcB   = ex.ALUSrcE ? ex.SignImmE : ex.rd2E;
  assign target = ex.pcE + ex.SignImmE;

  ex_alu #(.WIDTH(WIDTH)) alu (
    .a       (ex.SrcAE),
    .b       (srcB),
    .control (ex.AluControlE),
    .result  (aluRes),
    .zero    (zero)
  );

  assign ex.AluResultE = aluRes;

  // Stall (en=0) outranks flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex.ALUOutM       <= '0;
      ex.zeroM         <= BUBBLE_ZERO;
      ex.BranchTargetM <= '0;
      ex.WriteDataM    <= '0;
      ex.pcM           <= '0;
      ex.WriteRegM     <= BUBBLE_REG;
    end else if (en) begin
      if (flush) begin
        ex.ALUOutM       <= '0;
        ex.zeroM         <= BUBBLE_ZERO;
        ex.BranchTargetM <= '0;
        ex.WriteDataM    <= '0;
        ex.pcM           <= '0;
        ex.WriteRegM     <= BUBBLE_REG;
      end else begin
        ex.ALUOutM       <= aluRes;
        ex.zeroM         <= zero;
        ex.BranchTargetM <= target;
        ex.WriteDataM    <= ex.WriteDataE;
        ex.pcM           <= ex.pcE;
        ex.WriteRegM     <= ex.WriteRegE;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with an
// expected-result queue and immediate assertions.
module tb_execute_stage;
  import execute_stage_pkg::*;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] bt;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  wr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b1;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t hold;

  execute_stage_if #(.WIDTH(32)) bus ();

  execute_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .flush (flush),
    .ex    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chkOut(input string tag, input exp_t e);
    chk({tag, ".ALUOutM"}, bus.ALUOutM, e.alu);
    chk({tag, ".zeroM"}, {31'd0, bus.zeroM},
        {31'd0, e.zero});
    chk({tag, ".BranchTargetM"}, bus.BranchTargetM, e.bt);
    chk({tag, ".WriteDataM"}, bus.WriteDataM, e.wd);
    chk({tag, ".pcM"}, bus.pcM, e.pc);
    chk({tag, ".WriteRegM"}, {27'd0, bus.WriteRegM},
        {27'd0, e.wr});
  endtask

  task automatic drive(input logic [31:0] a, b, imm, pc,
                       input logic sel,
                       input logic [2:0] ctl,
                       input logic [4:0] wr);
    bus.SrcAE       = a;
    bus.rd2E        = b;
    bus.SignImmE    = imm;
    bus.pcE         = pc;
    bus.ALUSrcE     = sel;
    bus.AluControlE = ctl;
    bus.WriteDataE  = a ^ 32'h5A5A_0000;
    bus.WriteRegE   = wr;
  endtask

  task automatic popCheck(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty got=0 exp=1", tag);
    end else begin
      e = sb.pop_front();
      hold = e;
      chkOut(tag, e);
    end
  endtask

  task automatic step(input string tag,
                      input logic [31:0] a, b, imm, pc,
                      input logic sel,
                      input logic [2:0] ctl,
                      input logic [4:0] wr,
                      input logic [31:0] expAlu);
    exp_t e;
    drive(a, b, imm, pc, sel, ctl, wr);
    #1;
    chk({tag, ".AluResultE"}, bus.AluResultE, expAlu);
    e.alu  = expAlu;
    e.zero = (expAlu == 32'd0);
    e.bt   = pc + imm;
    e.wd   = a ^ 32'h5A5A_0000;
    e.pc   = pc;
    e.wr   = wr;
    sb.push_back(e);
    popCheck(tag);
  endtask

  initial begin
    exp_t z;
    z = '0;
    drive($urandom, $urandom, $urandom, $urandom,
          1'b0, ALU_ADD, 5'd9);
    repeat (2) @(posedge clk);
    #1;
    chkOut("reset", z);
    reset = 1'b1;

    step("add", 32'd5, 32'd7, 32'd0, 32'h40, 1'b0,
         ALU_ADD, 5'd1, 32'd12);
    step("and", 32'hF0F0_0000, 32'h0FF0_0001, 32'd8,
         32'h44, 1'b0, ALU_AND, 5'd2, 32'h00F0_0000);
    step("or", 32'hF0F0_0000, 32'h0FF0_0001, 32'd8,
         32'h48, 1'b0, ALU_OR, 5'd3, 32'hFFF0_0001);
    step("xor", 32'hF0F0_0000, 32'h0FF0_0001, 32'd8,
         32'h4C, 1'b0, ALU_XOR, 5'd4, 32'hFF00_0001);
    step("sub", 32'd9, 32'd9, 32'd16, 32'h50, 1'b0,
         ALU_SUB, 5'd5, 32'd0);
    step("slt", 32'hFFFF_FFFF, 32'd1, 32'd4, 32'h54,
         1'b0, ALU_SLT, 5'd6, 32'd1);
    step("sll", 32'd1, 32'd31, 32'd0, 32'h58, 1'b0,
         ALU_SLL, 5'd7, 32'h8000_0000);
    step("srl", 32'h8000_0000, 32'd31, 32'd0, 32'h5C,
         1'b0, ALU_SRL, 5'd8, 32'd1);
    step("imm", 32'd4, 32'hDEAD_BEEF, 32'hFFFF_FFFC,
         32'h100, 1'b1, ALU_ADD, 5'd10, 32'd0);
    chk("imm.BranchTarget.direct", bus.BranchTargetM,
        32'h0000_00FC);

    step("preStall", 32'h1234_0000, 32'h0000_5678,
         32'd12, 32'h200, 1'b0, ALU_OR, 5'd11,
         32'h1234_5678);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, $urandom,
            1'b0, ALU_SUB, 5'(i + 20));
      flush = i[0] ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      chkOut("stall", hold);
    end
    en = 1'b1;
    flush = 1'b1;
    drive(32'd3, 32'd3, 32'd0, 32'h300, 1'b0,
          ALU_SUB, 5'd7);
    sb.push_back(z);
    popCheck("flush");
    flush = 1'b0;

    step("preReset", 32'h10, 32'h20, 32'd4, 32'h400,
         1'b0, ALU_ADD, 5'd12, 32'h30);
    #3;
    reset = 1'b0;
    #1;
    chkOut("asyncReset", z);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipelined processor: selects the ALU B operand, performs the ALU operation, computes the PC-relative branch/jump target, and registers the results into the EX/MEM pipeline register. It sits between the decode register (`areg`) and the memory stage, and also drives the `ALUOutM`, `zeroM` and branch-target signals that fetch uses for redirect.

## Interface
- `WIDTH`, 32: datapath width; PC, operand and result width.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset (low clears every register).
- `en`  in  1: pipeline enable (`dhit`); 0 stalls the register.
- `flush`  in  1: `sendNop`; 1 loads a bubble.
- `pcE`  in  WIDTH: PC of the instruction in EX.
- `SrcAE`  in  WIDTH: ALU operand A.
- `rd2E`  in  WIDTH: register operand B.
- `SignImmE`  in  WIDTH: sign-extended immediate (byte offset).
- `ALUSrcE`  in  1: 0 selects `rd2E`, 1 selects `SignImmE` for operand B.
- `AluControlE`  in  3: operation select.
- `WriteDataE`  in  WIDTH: store data.
- `WriteRegE`  in  5: destination register.
- `AluResultE`  out  WIDTH: combinational ALU result, for forwarding.
- `ALUOutM`, `zeroM`, `BranchTargetM`, `WriteDataM`, `pcM`  out  WIDTH (`zeroM` is 1 bit): registered results.
- `WriteRegM`  out  5: registered destination register.

## Operation
- SrcB = `ALUSrcE` ? `SignImmE` : `rd2E`.
- `AluControlE` encoding:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 XOR
  - 100 SLL by SrcB[4:0]
  - 101 SRL (logical) by SrcB[4:0]
  - 110 SUB (A−B)
  - 111 SLT (signed A<B gives 1, else 0)
- Add/sub are modulo 2^WIDTH. Overflow is ignored and no carry is exported.
- zero = (AluResultE == 0), combinational.
- Branch target = `pcE` + `SignImmE`, modulo 2^WIDTH. The immediate is not shifted.
- The EX/MEM register captures AluResultE, zero, branch target, `WriteDataE`, `WriteRegE` and `pcE`.
- Bubble state: every register output is 0. In particular, `WriteRegM`=0 (x0, so no architectural write) and `zeroM`=0 (no spurious branch).

## Timing
- Reset (async, active-low):
  - All registered outputs go to 0 immediately and hold while `reset`=0.
  - Release is sampled on the next rising edge.
- Rising edge with `reset`=1:
  - `en`=0: hold all registers. Stall has priority over `flush`.
  - `en`=1, `flush`=1: load the bubble.
  - `en`=1, `flush`=0: load the EX values.
- Latency:
  - ALU result, zero and branch target: 1 cycle from EX inputs to `*M` outputs.
  - `AluResultE`: combinational, 0 cycles.
- Reset asserted mid-stall or mid-flush: reset wins asynchronously.

## Structure
- Shared package holds:
  - the `AluControl` encoding constants (ALU_AND … ALU_SLT);
  - the register-index width (5);
  - the bubble value.
- Natural sub-module: `ex_alu`, the purely combinational ALU with ports A, B, control, result and zero.
- The B-operand mux, the target adder and the EX/MEM register live in the top.

## Test plan
- Reset: hold `reset`=0 with arbitrary inputs → all `*M` outputs = 0. Release `reset`, apply ADD 5+7 with `ALUSrcE`=0, `en`=1 → after 1 edge `ALUOutM`=12, `zeroM`=0.
- ALU sweep:
  - A=0xF0F0_0000, B=0x0FF0_0001: AND→0x00F0_0000, OR→0xFFF0_0001, XOR→0xFF00_0001.
  - SUB of equal operands 9−9 → 0 with `zeroM`=1.
  - SLT −1 < 1 → 1.
  - SLL 1 by 31 → 0x8000_0000.
  - SRL 0x8000_0000 by 31 → 1.
- Immediate and branch target: `ALUSrcE`=1, `SignImmE`=0xFFFF_FFFC, `pcE`=0x100 → `BranchTargetM`=0xFC, `pcM`=0x100. With `SrcAE`=4 and ADD, `ALUOutM`=0.
- Stall: load a value, then hold `en`=0 for 3 cycles while changing inputs and pulsing `flush`=1 → outputs unchanged throughout.
- Flush: `en`=1, `flush`=1, `WriteRegE`=7, `SrcAE`=`rd2E`=3 with SUB → after the edge `WriteRegM`=0, `zeroM`=0, `ALUOutM`=0.
- Async reset mid-operation: pull `reset` low between clock edges with valid `*M` values → outputs = 0 before the next edge.
